// File: rtl/sram_dump.sv
// Walks a window of SRAM after the core halts and streams each word out over valid/ready,
// accumulating a wrap-around checksum of the accepted words.
module sram_dump #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DUMP_LEN  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_LEN - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_checksum;

    assign sram_rd_en = r_rd_en;
    assign sram_addr  = r_sram_addr;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_addr   = r_out_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign checksum   = r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_rd_en     <= 1'b0;
            r_sram_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= ISSUE;
                        r_ptr       <= BASE;
                        r_idx       <= '0;
                        r_checksum  <= '0;
                        r_rd_en     <= 1'b1;
                        r_sram_addr <= BASE;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_rd_en <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_out_data  <= sram_rd_data;
                    r_out_addr  <= r_ptr;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    // The next read is issued from the accept edge so each word costs 3 cycles.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_checksum  <= r_checksum + r_out_data;
                        if (r_idx == LAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            r_ptr       <= r_ptr + 1'b1;
                            r_rd_en     <= 1'b1;
                            r_sram_addr <= r_ptr + 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dump.sv
// Scoreboard bench for sram_dump: two instances (plain window at 0 and a window that wraps
// past the top of memory) share one synchronous SRAM model.
module tb_sram_dump;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];

    logic          rd0, rd1, v0, v1, b0, b1, d0, d1;
    logic [AW-1:0] sa0, sa1, oa0, oa1;
    logic [DW-1:0] rdd0, rdd1, od0, od1, cs0, cs1;
    logic          start0, start1;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    always @(posedge clk) begin
        if (rd0) rdd0 <= mem[sa0];
        if (rd1) rdd1 <= mem[sa1];
    end

    sram_dump #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .DUMP_LEN(4)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start0),
        .sram_rd_en(rd0), .sram_addr(sa0), .sram_rd_data(rdd0),
        .out_valid(v0), .out_ready(out_ready), .out_data(od0), .out_addr(oa0),
        .busy(b0), .done(d0), .checksum(cs0)
    );

    sram_dump #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(32'hFFFE), .DUMP_LEN(4)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1),
        .sram_rd_en(rd1), .sram_addr(sa1), .sram_rd_data(rdd1),
        .out_valid(v1), .out_ready(out_ready), .out_data(od1), .out_addr(oa1),
        .busy(b1), .done(d1), .checksum(cs1)
    );

    logic          obs_rd_en, obs_valid, obs_busy, obs_done;
    logic [AW-1:0] obs_saddr, obs_oaddr;
    logic [DW-1:0] obs_odata, obs_cs;

    assign obs_rd_en = sel ? rd1 : rd0;
    assign obs_saddr = sel ? sa1 : sa0;
    assign obs_valid = sel ? v1  : v0;
    assign obs_oaddr = sel ? oa1 : oa0;
    assign obs_odata = sel ? od1 : od0;
    assign obs_busy  = sel ? b1  : b0;
    assign obs_done  = sel ? d1  : d0;
    assign obs_cs    = sel ? cs1 : cs0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t q[$];
    int   acc_t[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   acc_n  = 0;
    int   cyc    = 0;
    exp_t e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (obs_rd_en) rd_cnt++;
        if (rst_n && obs_valid && out_ready) begin
            checks++;
            acc_n++;
            acc_t.push_back(cyc);
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got addr=%h data=%h required none", obs_oaddr, obs_odata);
            end else begin
                e_mon = q.pop_front();
                if ({obs_oaddr, obs_odata} !== {e_mon.a, e_mon.d}) begin
                    errors++;
                    $display("FAIL word got addr=%h data=%h required addr=%h data=%h",
                             obs_oaddr, obs_odata, e_mon.a, e_mon.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_window(input logic [AW-1:0] base, input int n, output logic [DW-1:0] sum);
        exp_t e;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            e.a = base + AW'(i);
            e.d = mem[e.a];
            q.push_back(e);
            sum += e.d;
        end
    endtask

    task automatic prep();
        q.delete();
        acc_t.delete();
        rd_cnt = 0;
        acc_n  = 0;
    endtask

    task automatic test_reset();
        int bad = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (10) begin
            tick();
            if (rd0 || rd1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_rd_en got %0d pulses required 0", bad);
        end
        checks++;
        if ({rd0, sa0, v0, od0, oa0, b0, d0, cs0, rd1, sa1, v1, od1, oa1, b1, d1, cs1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b%b busy=%b%b done=%b%b cs=%h/%h required all 0",
                     v0, v1, b0, b1, d0, d1, cs0, cs1);
        end
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] esum;
        int t0;
        sel = 1'b0;
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done) begin
            errors++;
            $display("FAIL basic_done got 0 required 1 (timeout)");
        end
        checks++;
        if (cyc - t0 != 13) begin
            errors++;
            $display("FAIL basic_done_cycle got %0d required 13", cyc - t0);
        end
        checks++;
        if (acc_t.size() != 4) begin
            errors++;
            $display("FAIL basic_word_count got %0d required 4", acc_t.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_t[k] - t0 != 3 * (k + 1)) begin
                    errors++;
                    $display("FAIL basic_word_timing got %0d required %0d", acc_t[k] - t0, 3 * (k + 1));
                end
            end
        end
        checks++;
        if (obs_cs !== 32'd10 || obs_cs !== esum) begin
            errors++;
            $display("FAIL basic_checksum got %h required %h", obs_cs, 32'd10);
        end
        checks++;
        if (rd_cnt != 4 || obs_busy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL basic_end got rd=%0d busy=%b left=%0d required rd=4 busy=0 left=0",
                     rd_cnt, obs_busy, q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] esum;
        int rd_before;
        int held_bad = 0;
        sel = 1'b0;
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 30 && !(obs_rd_en && obs_saddr == 16'h0001); n++) tick();
        out_ready = 1'b0;
        for (int n = 0; n < 10 && !obs_valid; n++) tick();
        checks++;
        if (!obs_valid) begin
            errors++;
            $display("FAIL bp_word2_valid got 0 required 1 (timeout)");
        end
        rd_before = rd_cnt;
        repeat (7) begin
            if (!obs_valid || obs_odata !== mem[1] || obs_oaddr !== 16'h0001) held_bad++;
            tick();
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles required 0", held_bad);
        end
        checks++;
        if (rd_cnt != rd_before) begin
            errors++;
            $display("FAIL bp_no_reads got %0d required %0d", rd_cnt, rd_before);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done || rd_cnt != 4 || q.size() != 0 || obs_cs !== esum) begin
            errors++;
            $display("FAIL bp_end got done=%b rd=%0d left=%0d cs=%h required done=1 rd=4 left=0 cs=%h",
                     obs_done, rd_cnt, q.size(), obs_cs, esum);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] esum;
        sel = 1'b1;
        prep();
        push_window(16'hFFFE, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 30 && acc_n < 2; n++) tick();
        checks++;
        if (obs_cs !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_partial_checksum got %h required 00000000", obs_cs);
        end
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done || rd_cnt != 4 || q.size() != 0 || obs_cs !== esum) begin
            errors++;
            $display("FAIL wrap_end got done=%b rd=%0d left=%0d cs=%h required done=1 rd=4 left=0 cs=%h",
                     obs_done, rd_cnt, q.size(), obs_cs, esum);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] esum;
        int rd_before;
        sel = 1'b0;
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 30 && !(obs_valid && obs_oaddr == 16'h0001); n++) tick();
        checks++;
        if (!(obs_valid && obs_oaddr == 16'h0001)) begin
            errors++;
            $display("FAIL abort_reach_word2 got valid=%b addr=%h required valid=1 addr=0001",
                     obs_valid, obs_oaddr);
        end
        rst_n = 1'b0;
        q.delete();
        tick();
        tick();
        checks++;
        if ({obs_valid, obs_done, obs_busy, obs_rd_en, obs_cs} !== '0) begin
            errors++;
            $display("FAIL abort_state got valid=%b done=%b busy=%b cs=%h required all 0",
                     obs_valid, obs_done, obs_busy, obs_cs);
        end
        rst_n = 1'b1;
        rd_before = rd_cnt;
        repeat (5) tick();
        checks++;
        if (rd_cnt != rd_before || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got rd=%0d valid=%b required rd=%0d valid=0",
                     rd_cnt, obs_valid, rd_before);
        end
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done || rd_cnt != 4 || q.size() != 0 || obs_cs !== esum) begin
            errors++;
            $display("FAIL abort_redump got done=%b rd=%0d left=%0d cs=%h required done=1 rd=4 left=0 cs=%h",
                     obs_done, rd_cnt, q.size(), obs_cs, esum);
        end
    endtask

    task automatic test_restart();
        logic [DW-1:0] esum;
        sel = 1'b0;
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done || rd_cnt != 4 || q.size() != 0 || obs_cs !== esum) begin
            errors++;
            $display("FAIL restart_ignore got done=%b rd=%0d left=%0d cs=%h required done=1 rd=4 left=0 cs=%h",
                     obs_done, rd_cnt, q.size(), obs_cs, esum);
        end
        prep();
        push_window(16'h0000, 4, esum);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs_done !== 1'b0 || obs_rd_en !== 1'b1 || obs_busy !== 1'b1 || obs_cs !== '0) begin
            errors++;
            $display("FAIL restart_issue got done=%b rd_en=%b busy=%b cs=%h required done=0 rd_en=1 busy=1 cs=0",
                     obs_done, obs_rd_en, obs_busy, obs_cs);
        end
        for (int n = 0; n < 60 && !obs_done; n++) tick();
        checks++;
        if (!obs_done || rd_cnt != 4 || q.size() != 0 || obs_cs !== esum) begin
            errors++;
            $display("FAIL restart_second got done=%b rd=%0d left=%0d cs=%h required done=1 rd=4 left=0 cs=%h",
                     obs_done, rd_cnt, q.size(), obs_cs, esum);
        end
    endtask

    initial begin
        mem[16'h0000] = 32'd1;
        mem[16'h0001] = 32'd2;
        mem[16'h0002] = 32'd3;
        mem[16'h0003] = 32'd4;
        mem[16'hFFFE] = 32'hFFFF_FFFF;
        mem[16'hFFFF] = 32'd1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_restart();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
